// File: rtl/cmd_slave_pkg.sv
// Shared constants, command encoding and bin-index helper for cmd_slave.
package cmd_slave_pkg;

  localparam int CW     = 4;
  localparam int AW     = 4;
  localparam int DW     = 4;
  localparam int N_CMD  = 16;
  localparam int N_ADR  = 16;
  localparam int N_BINS = 256;

  typedef enum logic [3:0] {
    CMD_NOP     = 4'd0,
    CMD_WRITE   = 4'd1,
    CMD_READ    = 4'd2,
    CMD_CLR_COV = 4'd3
  } cmd_e;

  // Coverage bin index: command code in the upper bits, address below.
  function automatic logic [CW+AW-1:0] bin_index(input logic [CW-1:0] cmd,
                                                 input logic [AW-1:0] adr);
    return {cmd, adr};
  endfunction

endpackage

// File: rtl/cov_bitmap.sv
// Unique-hit coverage tracker: one bit per bin, distinct-hit counter,
// one-cycle pulse on the first hit of each bin, synchronous clear.
module cov_bitmap
  import cmd_slave_pkg::*;
#(
  parameter int IW = CW + AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rec,
  input  logic          clr,
  input  logic [IW-1:0] idx,
  output logic          new_bin,
  output logic [IW:0]   bins_hit,
  output logic          all_hit
);

  localparam int NB = 1 << IW;

  logic [NB-1:0] hit_r;
  logic [IW:0]   count_r;
  logic          new_bin_r;
  logic          fresh_s;

  // A recorded sample is fresh when its bin has not been hit since the last clear.
  always_comb begin
    fresh_s = 1'b0;
    if (rec && !clr) begin
      fresh_s = !hit_r[idx];
    end else begin
      fresh_s = 1'b0;
    end
  end

  // Bitmap, counter and pulse update; clear wins over recording.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_r     <= '0;
      count_r   <= '0;
      new_bin_r <= 1'b0;
    end else if (clr) begin
      hit_r     <= '0;
      count_r   <= '0;
      new_bin_r <= 1'b0;
    end else begin
      new_bin_r <= fresh_s;
      if (fresh_s) begin
        hit_r[idx] <= 1'b1;
        count_r    <= count_r + {{IW{1'b0}}, 1'b1};
      end
    end
  end

  assign new_bin  = new_bin_r;
  assign bins_hit = count_r;
  // Counter can never pass the bin count, so equality marks completion.
  assign all_hit  = (count_r == (IW+1)'(NB));

endmodule

// File: rtl/cmd_slave.sv
// Bus slave: decodes sampled commands into register-file writes/reads
// and feeds every non-clear sample into the coverage tracker.
module cmd_slave
  import cmd_slave_pkg::*;
#(
  parameter int CW = cmd_slave_pkg::CW,
  parameter int AW = cmd_slave_pkg::AW,
  parameter int DW = cmd_slave_pkg::DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CW-1:0]    cmd,
  input  logic [AW-1:0]    adr,
  input  logic [DW-1:0]    data,
  output logic [DW-1:0]    rdata,
  output logic             rvalid,
  output logic             new_bin,
  output logic [CW+AW:0]   bins_hit,
  output logic             all_hit
);

  localparam int NR = 1 << AW;

  logic [DW-1:0] regs_r [NR];
  logic [DW-1:0] rdata_r;
  logic          rvalid_r;
  logic          valid_s;
  logic          do_write_s;
  logic          do_read_s;
  logic          do_clr_s;
  logic          do_rec_s;

  // Command decode; unknown cmd/adr (simulation only) degrades to an unrecorded NOP.
  always_comb begin
    valid_s    = !$isunknown({cmd, adr});
    do_write_s = 1'b0;
    do_read_s  = 1'b0;
    do_clr_s   = 1'b0;
    do_rec_s   = 1'b0;
    if (valid_s) begin
      case (cmd)
        CW'(CMD_WRITE): begin
          do_write_s = 1'b1;
          do_rec_s   = 1'b1;
        end
        CW'(CMD_READ): begin
          do_read_s = 1'b1;
          do_rec_s  = 1'b1;
        end
        CW'(CMD_CLR_COV): begin
          do_clr_s = 1'b1;
        end
        default: begin
          do_rec_s = 1'b1;
        end
      endcase
    end else begin
      do_rec_s = 1'b0;
    end
  end

  // Register file: cleared by reset, written at the sampling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        regs_r[i] <= '0;
      end
    end else if (do_write_s) begin
      regs_r[adr] <= data;
    end
  end

  // Read pipeline: one-cycle rvalid pulse, rdata holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_r  <= '0;
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= do_read_s;
      if (do_read_s) begin
        rdata_r <= regs_r[adr];
      end
    end
  end

  assign rdata  = rdata_r;
  assign rvalid = rvalid_r;

  cov_bitmap #(
    .IW (CW + AW)
  ) u_cov (
    .clk      (clk),
    .rst      (rst),
    .rec      (do_rec_s),
    .clr      (do_clr_s),
    .idx      ({cmd, adr}),
    .new_bin  (new_bin),
    .bins_hit (bins_hit),
    .all_hit  (all_hit)
  );

endmodule

// File: tb/tb_cmd_slave.sv
// Self-checking bench for cmd_slave: directed table, reset/sweep sequences,
// randomized traffic against a behavioural model, and a cov_bitmap unit test.
module tb_cmd_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] cmd = 4'd0;
  logic [3:0] adr = 4'd0;
  logic [3:0] data = 4'd0;
  logic [3:0] rdata;
  logic       rvalid;
  logic       new_bin;
  logic [8:0] bins_hit;
  logic       all_hit;

  logic       cv_rec = 1'b0;
  logic       cv_clr = 1'b0;
  logic [7:0] cv_idx = 8'd0;
  logic       cv_new;
  logic [8:0] cv_bins;
  logic       cv_all;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cmd_slave dut (
    .clk(clk), .rst(rst), .cmd(cmd), .adr(adr), .data(data),
    .rdata(rdata), .rvalid(rvalid), .new_bin(new_bin),
    .bins_hit(bins_hit), .all_hit(all_hit)
  );

  cov_bitmap #(.IW(8)) u_cov_unit (
    .clk(clk), .rst(rst), .rec(cv_rec), .clr(cv_clr), .idx(cv_idx),
    .new_bin(cv_new), .bins_hit(cv_bins), .all_hit(cv_all)
  );

  // ---------------- behavioural reference model ----------------
  int unsigned m_mem [16];
  bit          m_seen [16][16];
  int unsigned m_rdata;
  bit          m_rvalid;
  bit          m_new;
  int unsigned m_bins;

  task automatic model_reset();
    foreach (m_mem[i]) m_mem[i] = 0;
    foreach (m_seen[c, a]) m_seen[c][a] = 1'b0;
    m_rdata = 0; m_rvalid = 0; m_new = 0; m_bins = 0;
  endtask

  task automatic model_step(input int unsigned c, input int unsigned a, input int unsigned d);
    m_rvalid = (c == 2);
    if (m_rvalid) m_rdata = m_mem[a];
    if (c == 1) m_mem[a] = d;
    if (c == 3) begin
      foreach (m_seen[i, j]) m_seen[i][j] = 1'b0;
      m_new = 0;
    end else begin
      m_new = !m_seen[c][a];
      m_seen[c][a] = 1'b1;
    end
    m_bins = 0;
    foreach (m_seen[i, j]) if (m_seen[i][j]) m_bins++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    check("rvalid", {31'd0, rvalid}, {31'd0, m_rvalid});
    check("rdata", {28'd0, rdata}, m_rdata);
    check("new_bin", {31'd0, new_bin}, {31'd0, m_new});
    check("bins_hit", {23'd0, bins_hit}, m_bins);
    check("all_hit", {31'd0, all_hit}, {31'd0, (m_bins == 256)});
  endtask

  // Drive one sample, advance the model, check just after the edge.
  task automatic apply(input logic [3:0] c, input logic [3:0] a, input logic [3:0] d);
    cmd = c; adr = a; data = d;
    model_step(c, a, d);
    @(posedge clk);
    #1;
    check_model();
  endtask

  typedef struct {
    logic [3:0] c;
    logic [3:0] a;
    logic [3:0] d;
    logic       rv;
    logic [3:0] rd;
    logic       nb;
    logic [8:0] bh;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{4'd1,  4'd5, 4'd9, 1'b0, 4'd0, 1'b1, 9'd1};  // WRITE 5<=9
    tbl[1]  = '{4'd2,  4'd5, 4'd0, 1'b1, 4'd9, 1'b1, 9'd2};  // READ 5
    tbl[2]  = '{4'd0,  4'd0, 4'd0, 1'b0, 4'd9, 1'b1, 9'd3};  // rvalid drops, rdata holds
    tbl[3]  = '{4'd0,  4'd3, 4'd0, 1'b0, 4'd9, 1'b1, 9'd4};  // NOP adr3 first hit
    tbl[4]  = '{4'd0,  4'd3, 4'd0, 1'b0, 4'd9, 1'b0, 9'd4};  // repeat hit
    tbl[5]  = '{4'd2,  4'd3, 4'd0, 1'b1, 4'd0, 1'b1, 9'd5};  // READ adr3
    tbl[6]  = '{4'd1,  4'd7, 4'd6, 1'b0, 4'd0, 1'b1, 9'd6};  // WRITE 7<=6
    tbl[7]  = '{4'd12, 4'd7, 4'd4, 1'b0, 4'd0, 1'b1, 9'd7};  // reserved: no store
    tbl[8]  = '{4'd2,  4'd7, 4'd0, 1'b1, 4'd6, 1'b1, 9'd8};  // READ 7 still 6
    tbl[9]  = '{4'd3,  4'd0, 4'd0, 1'b0, 4'd6, 1'b0, 9'd0};  // CLR_COV
    tbl[10] = '{4'd3,  4'd0, 4'd0, 1'b0, 4'd6, 1'b0, 9'd0};  // CLR_COV not recorded
    tbl[11] = '{4'd2,  4'd7, 4'd0, 1'b1, 4'd6, 1'b1, 9'd1};  // first hit after clear

    model_reset();
    #3;
    check("rst_rdata", {28'd0, rdata}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_new_bin", {31'd0, new_bin}, 32'd0);
    check("rst_bins_hit", {23'd0, bins_hit}, 32'd0);
    check("rst_all_hit", {31'd0, all_hit}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      apply(tbl[i].c, tbl[i].a, tbl[i].d);
      check($sformatf("tbl%0d_rvalid", i), {31'd0, rvalid}, {31'd0, tbl[i].rv});
      check($sformatf("tbl%0d_rdata", i), {28'd0, rdata}, {28'd0, tbl[i].rd});
      check($sformatf("tbl%0d_new_bin", i), {31'd0, new_bin}, {31'd0, tbl[i].nb});
      check($sformatf("tbl%0d_bins_hit", i), {23'd0, bins_hit}, {23'd0, tbl[i].bh});
    end

    // Mid-cycle reset cancels a pending read pulse and clears storage
    apply(4'd2, 4'd5, 4'd0);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("midrst_rdata", {28'd0, rdata}, 32'd0);
    check("midrst_rvalid", {31'd0, rvalid}, 32'd0);
    check("midrst_new_bin", {31'd0, new_bin}, 32'd0);
    check("midrst_bins_hit", {23'd0, bins_hit}, 32'd0);
    #1 rst = 1'b0;
    apply(4'd2, 4'd5, 4'd0);
    check("midrst_mem_cleared", {28'd0, rdata}, 32'd0);

    // Sweep every pair except CLR_COV
    apply(4'd3, 4'd0, 4'd0);
    for (int c = 0; c < 16; c++) begin
      if (c != 3) begin
        for (int a = 0; a < 16; a++) begin
          apply(4'(c), 4'(a), 4'($urandom_range(0, 15)));
        end
      end
    end
    check("sweep240_bins_hit", {23'd0, bins_hit}, 32'd240);
    check("sweep240_all_hit", {31'd0, all_hit}, 32'd0);
    apply(4'd3, 4'd9, 4'd0);
    check("sweep_clr_bins_hit", {23'd0, bins_hit}, 32'd0);

    // Sweep all 256 pairs including CLR_COV: completion never reached
    for (int c = 0; c < 16; c++) begin
      for (int a = 0; a < 16; a++) begin
        apply(4'(c), 4'(a), 4'($urandom_range(0, 15)));
      end
    end
    check("sweep256_all_hit", {31'd0, all_hit}, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int unsigned sel;
      logic [3:0]  c;
      sel = $urandom_range(0, 99);
      if (sel < 30)      c = 4'd1;
      else if (sel < 60) c = 4'd2;
      else if (sel < 62) c = 4'd3;
      else               c = 4'($urandom_range(0, 15));
      apply(c, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    // cov_bitmap unit test: completion path
    cmd = 4'd0; adr = 4'd0;
    @(negedge clk);
    cv_clr = 1'b1;
    @(negedge clk);
    cv_clr = 1'b0;
    check("unit_clr_bins", {23'd0, cv_bins}, 32'd0);
    for (int i = 0; i < 256; i++) begin
      cv_rec = 1'b1; cv_idx = 8'(i);
      @(posedge clk);
      #1;
      check("unit_new_bin", {31'd0, cv_new}, 32'd1);
      if (i == 254) check("unit_all_hit_255", {31'd0, cv_all}, 32'd0);
    end
    check("unit_bins_256", {23'd0, cv_bins}, 32'd256);
    check("unit_all_hit", {31'd0, cv_all}, 32'd1);
    cv_idx = 8'd0;
    @(posedge clk);
    #1;
    check("unit_repeat_new_bin", {31'd0, cv_new}, 32'd0);
    check("unit_repeat_bins", {23'd0, cv_bins}, 32'd256);
    cv_rec = 1'b0; cv_clr = 1'b1;
    @(posedge clk);
    #1;
    cv_clr = 1'b0;
    check("unit_final_clr_bins", {23'd0, cv_bins}, 32'd0);
    check("unit_final_clr_all", {31'd0, cv_all}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
